// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared types and constants for the MIPS pipeline registers.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam int DATA_W     = 16;
    localparam int REG_W      = 4;
    localparam int ALU_CTRL_W = 4;

    localparam logic [ALU_CTRL_W-1:0] ALU_NOP = 4'b0000;

    typedef struct packed {
        logic                  writeEN1;
        logic                  writeEN2;
        logic                  Op1Mux;
        logic                  Op2Mux;
        logic                  dataMemWR;
        logic                  dataMemRD;
        logic                  dirALUMux;
        logic                  wbMUX;
        logic [ALU_CTRL_W-1:0] aLUControl;
    } ctrl_t;

    localparam ctrl_t BUBBLE_CTRL = '{
        writeEN1:   1'b0,
        writeEN2:   1'b0,
        Op1Mux:     1'b0,
        Op2Mux:     1'b0,
        dataMemWR:  1'b0,
        dataMemRD:  1'b0,
        dirALUMux:  1'b0,
        wbMUX:      1'b0,
        aLUControl: ALU_NOP
    };

endpackage
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// ============================================================================
// Module      : hazard_detect
// Description : Combinational load-use hazard detection and stall request.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_detect #(
    parameter int REG_W = 4
) (
    input  logic             i_ex_valid,
    input  logic             i_ex_dataMemRD,
    input  logic [REG_W-1:0] i_ex_rd_addr,
    input  logic             i_id_valid,
    input  logic             i_id_Op2Mux,
    input  logic [REG_W-1:0] i_id_rs_addr,
    input  logic [REG_W-1:0] i_id_rt_addr,
    input  logic             i_ex_flush,
    input  logic             i_ex_hold,
    output logic             o_load_use,
    output logic             o_stall
);

    logic w_rs_match;
    logic w_rt_match;

    // rt only matters as a source when Op2Mux selects the register, not the immediate
    assign w_rs_match = (i_ex_rd_addr == i_id_rs_addr);
    assign w_rt_match = !i_id_Op2Mux && (i_ex_rd_addr == i_id_rt_addr);

    assign o_load_use = i_ex_valid && i_ex_dataMemRD && i_id_valid
                        && (i_ex_rd_addr != '0) && (w_rs_match || w_rt_match);

    assign o_stall = (o_load_use || i_ex_hold) && !i_ex_flush;

endmodule
`default_nettype wire

// File: rtl/id_ex_register.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_register
// Description : ID/EX pipeline register with load-use bubble, flush, hold
//               and a saturating bubble counter.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_register #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic              id_writeEN1,
    input  logic              id_writeEN2,
    input  logic              id_Op1Mux,
    input  logic              id_Op2Mux,
    input  logic              id_dataMemWR,
    input  logic              id_dataMemRD,
    input  logic              id_dirALUMux,
    input  logic              id_wbMUX,
    input  logic [3:0]        id_aLUControl,
    input  logic [REG_W-1:0]  id_rs_addr,
    input  logic [REG_W-1:0]  id_rt_addr,
    input  logic [REG_W-1:0]  id_rd_addr,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              ex_flush,
    input  logic              ex_hold,
    output logic              ex_valid,
    output logic              ex_writeEN1,
    output logic              ex_writeEN2,
    output logic              ex_Op1Mux,
    output logic              ex_Op2Mux,
    output logic              ex_dataMemWR,
    output logic              ex_dataMemRD,
    output logic              ex_dirALUMux,
    output logic              ex_wbMUX,
    output logic [3:0]        ex_aLUControl,
    output logic [REG_W-1:0]  ex_rs_addr,
    output logic [REG_W-1:0]  ex_rt_addr,
    output logic [REG_W-1:0]  ex_rd_addr,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic              stall,
    output logic [CNT_W-1:0]  bubble_cnt
);

    import mips_pkg::*;

    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    ctrl_t              w_id_ctrl;
    ctrl_t              r_ex_ctrl;
    logic               r_ex_valid;
    logic [REG_W-1:0]   r_ex_rs_addr;
    logic [REG_W-1:0]   r_ex_rt_addr;
    logic [REG_W-1:0]   r_ex_rd_addr;
    logic [DATA_W-1:0]  r_ex_rs_data;
    logic [DATA_W-1:0]  r_ex_rt_data;
    logic [DATA_W-1:0]  r_ex_imm;
    logic [CNT_W-1:0]   r_bubble_cnt;
    logic               w_load_use;
    logic               w_stall;

    assign w_id_ctrl = '{
        writeEN1:   id_writeEN1,
        writeEN2:   id_writeEN2,
        Op1Mux:     id_Op1Mux,
        Op2Mux:     id_Op2Mux,
        dataMemWR:  id_dataMemWR,
        dataMemRD:  id_dataMemRD,
        dirALUMux:  id_dirALUMux,
        wbMUX:      id_wbMUX,
        aLUControl: id_aLUControl
    };

    hazard_detect #(
        .REG_W (REG_W)
    ) u_hazard_detect (
        .i_ex_valid     (r_ex_valid),
        .i_ex_dataMemRD (r_ex_ctrl.dataMemRD),
        .i_ex_rd_addr   (r_ex_rd_addr),
        .i_id_valid     (id_valid),
        .i_id_Op2Mux    (id_Op2Mux),
        .i_id_rs_addr   (id_rs_addr),
        .i_id_rt_addr   (id_rt_addr),
        .i_ex_flush     (ex_flush),
        .i_ex_hold      (ex_hold),
        .o_load_use     (w_load_use),
        .o_stall        (w_stall)
    );

    // Priority: flush > hold > load-use bubble > load (invalid ID loads as bubble)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid   <= 1'b0;
            r_ex_ctrl    <= BUBBLE_CTRL;
            r_ex_rs_addr <= '0;
            r_ex_rt_addr <= '0;
            r_ex_rd_addr <= '0;
            r_ex_rs_data <= '0;
            r_ex_rt_data <= '0;
            r_ex_imm     <= '0;
        end else if (ex_hold && !ex_flush) begin
            r_ex_valid   <= r_ex_valid;
        end else if (ex_flush || w_load_use || !id_valid) begin
            r_ex_valid   <= 1'b0;
            r_ex_ctrl    <= BUBBLE_CTRL;
            r_ex_rs_addr <= '0;
            r_ex_rt_addr <= '0;
            r_ex_rd_addr <= '0;
            r_ex_rs_data <= '0;
            r_ex_rt_data <= '0;
            r_ex_imm     <= '0;
        end else begin
            r_ex_valid   <= 1'b1;
            r_ex_ctrl    <= w_id_ctrl;
            r_ex_rs_addr <= id_rs_addr;
            r_ex_rt_addr <= id_rt_addr;
            r_ex_rd_addr <= id_rd_addr;
            r_ex_rs_data <= id_rs_data;
            r_ex_rt_data <= id_rt_data;
            r_ex_imm     <= id_imm;
        end
    end

    // Only load-use bubbles count; flush and hold both suppress the increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bubble_cnt <= '0;
        end else if (w_load_use && !ex_flush && !ex_hold && (r_bubble_cnt != C_CNT_MAX)) begin
            r_bubble_cnt <= r_bubble_cnt + C_CNT_ONE;
        end
    end

    assign ex_valid      = r_ex_valid;
    assign ex_writeEN1   = r_ex_ctrl.writeEN1;
    assign ex_writeEN2   = r_ex_ctrl.writeEN2;
    assign ex_Op1Mux     = r_ex_ctrl.Op1Mux;
    assign ex_Op2Mux     = r_ex_ctrl.Op2Mux;
    assign ex_dataMemWR  = r_ex_ctrl.dataMemWR;
    assign ex_dataMemRD  = r_ex_ctrl.dataMemRD;
    assign ex_dirALUMux  = r_ex_ctrl.dirALUMux;
    assign ex_wbMUX      = r_ex_ctrl.wbMUX;
    assign ex_aLUControl = r_ex_ctrl.aLUControl;
    assign ex_rs_addr    = r_ex_rs_addr;
    assign ex_rt_addr    = r_ex_rt_addr;
    assign ex_rd_addr    = r_ex_rd_addr;
    assign ex_rs_data    = r_ex_rs_data;
    assign ex_rt_data    = r_ex_rt_data;
    assign ex_imm        = r_ex_imm;
    assign stall         = w_stall;
    assign bubble_cnt    = r_bubble_cnt;

endmodule
`default_nettype wire
